// File: rtl/numeric_readout.sv
// numeric_readout
// Draws a right-aligned decimal number (optionally followed by a degree sign)
// as a row of 16x32 glyph tiles, magnified by 2^SCALE_LOG2, at (X0, Y0).
// A binary value is converted to BCD one bit per clock (shift-add-3). The
// result waits in PENDING until the next frame_start, where it becomes the
// displayed codes, so a frame is never drawn with a half-updated number.
//
// Ports:
//   clk         pixel clock
//   reset       synchronous, active-high
//   x, y        current pixel column / row
//   frame_start one-cycle pulse at start of frame (commit point)
//   value       unsigned binary value, sampled on value_valid
//   value_valid one-cycle strobe
//   busy        conversion in progress
//   overflow    committed value does not fit in N_DIGITS digits
//   on_char     pixel lit, two cycles after x/y
module numeric_readout #(
  parameter int X0          = 0,
  parameter int Y0          = 0,
  parameter int N_DIGITS    = 3,
  parameter int VALUE_W     = 10,
  parameter int SCALE_LOG2  = 0,
  parameter int LZ_BLANK    = 1,
  parameter int UNIT_DEGREE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               frame_start,
  input  logic [VALUE_W-1:0] value,
  input  logic               value_valid,
  output logic               busy,
  output logic               overflow,
  output logic               on_char
);

  localparam int N_CHARS = N_DIGITS + UNIT_DEGREE;
  localparam int TW      = 16 << SCALE_LOG2;
  localparam int TH      = 32 << SCALE_LOG2;
  localparam int BCD_W   = 4 * N_DIGITS;
  localparam int CNT_W   = 5;

  localparam logic [3:0] CODE_BLANK  = 4'hA;
  localparam logic [3:0] CODE_DASH   = 4'hB;
  localparam logic [3:0] CODE_DEGREE = 4'hC;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam logic [63:0] OVF_LIMIT = pow10(N_DIGITS);

  // Glyph font. Digits are built from seven thick segments (bit 0 = top,
  // 1 = upper right, 2 = lower right, 3 = bottom, 4 = lower left,
  // 5 = upper left, 6 = middle) so every digit is fully drawn without a ROM.
  function automatic logic glyph_bit(input logic [3:0] code,
                                     input logic [4:0] row,
                                     input logic [3:0] col);
    logic [6:0] segs;
    logic       r_top, r_mid, r_bot, r_upper, r_lower;
    logic       c_left, c_right, c_span;
    logic       lit;
    r_top   = (row >= 5'd2)  && (row <= 5'd4);
    r_mid   = (row == 5'd15) || (row == 5'd16);
    r_bot   = (row >= 5'd27) && (row <= 5'd29);
    r_upper = (row >= 5'd2)  && (row <= 5'd16);
    r_lower = (row >= 5'd15) && (row <= 5'd29);
    c_left  = (col >= 4'd2)  && (col <= 4'd4);
    c_right = (col >= 4'd11) && (col <= 4'd13);
    c_span  = (col >= 4'd2)  && (col <= 4'd13);
    case (code)
      4'd0:    segs = 7'h3F;
      4'd1:    segs = 7'h06;
      4'd2:    segs = 7'h5B;
      4'd3:    segs = 7'h4F;
      4'd4:    segs = 7'h66;
      4'd5:    segs = 7'h6D;
      4'd6:    segs = 7'h7D;
      4'd7:    segs = 7'h07;
      4'd8:    segs = 7'h7F;
      4'd9:    segs = 7'h6F;
      default: segs = 7'h00;
    endcase
    lit = (segs[0] && r_top   && c_span)  ||
          (segs[1] && r_upper && c_right) ||
          (segs[2] && r_lower && c_right) ||
          (segs[3] && r_bot   && c_span)  ||
          (segs[4] && r_lower && c_left)  ||
          (segs[5] && r_upper && c_left)  ||
          (segs[6] && r_mid   && c_span);
    if (code == CODE_DASH) begin
      lit = r_mid && (col >= 4'd3) && (col <= 4'd12);
    end else if (code == CODE_DEGREE) begin
      lit = (row >= 5'd1) && (row <= 5'd6) && (col >= 4'd2) && (col <= 4'd7) &&
            ((row == 5'd1) || (row == 5'd6) || (col == 4'd2) || (col == 4'd7));
    end else begin
      lit = lit;
    end
    return lit;
  endfunction

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [VALUE_W-1:0] r_value;
  logic [VALUE_W-1:0] r_shift;
  logic [BCD_W-1:0]   r_bcd;
  logic [3:0]         r_codes [N_CHARS];
  logic               r_busy;
  logic               r_overflow;

  logic [BCD_W-1:0]   w_bcd_adj;
  logic [BCD_W-1:0]   w_bcd_next;
  logic               w_ovf;
  logic [3:0]         w_codes [N_CHARS];

  // Shift-add-3 step: correct every nibble >= 5, then shift in the next MSB.
  // Nibbles above N_DIGITS are dropped; an oversized value shows dashes anyway.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end else begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4];
      end
    end
    w_bcd_next = {w_bcd_adj[BCD_W-2:0], r_shift[VALUE_W-1]};
  end

  // Tile codes that a commit would load, derived from the finished BCD.
  always_comb begin
    logic       v_lead;
    logic [3:0] v_nib;
    int         v_sh;
    w_ovf  = (64'(r_value) >= OVF_LIMIT);
    v_lead = (LZ_BLANK != 0);
    for (int i = 0; i < N_CHARS; i++) begin
      v_sh  = (i < N_DIGITS) ? 4 * (N_DIGITS - 1 - i) : 0;
      v_nib = 4'(r_bcd >> v_sh);
      if (i >= N_DIGITS) begin
        w_codes[i] = CODE_DEGREE;
      end else if (w_ovf) begin
        w_codes[i] = CODE_DASH;
      end else if (v_lead && (v_nib == 4'd0) && (i != N_DIGITS - 1)) begin
        // least-significant tile is exempt so zero still shows as "0"
        w_codes[i] = CODE_BLANK;
      end else begin
        w_codes[i] = v_nib;
        v_lead     = 1'b0;
      end
    end
  end

  // Conversion FSM and commit of displayed codes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_value    <= {VALUE_W{1'b0}};
      r_shift    <= {VALUE_W{1'b0}};
      r_bcd      <= {BCD_W{1'b0}};
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      for (int i = 0; i < N_CHARS; i++) begin
        r_codes[i] <= CODE_BLANK;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (value_valid) begin
            r_value <= value;
            r_shift <= value;
            r_bcd   <= {BCD_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b1;
            r_state <= ST_CONVERT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CONVERT: begin
          r_bcd   <= w_bcd_next;
          r_shift <= r_shift << 1;
          if (r_cnt == CNT_W'(VALUE_W - 1)) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
            r_state <= ST_PENDING;
          end else begin
            r_cnt   <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_PENDING: begin
          if (frame_start) begin
            r_overflow <= w_ovf;
            for (int i = 0; i < N_CHARS; i++) begin
              r_codes[i] <= w_codes[i];
            end
          end else begin
            r_overflow <= r_overflow;
          end
          // a new strobe restarts conversion; the commit above uses the old result
          if (value_valid) begin
            r_value <= value;
            r_shift <= value;
            r_bcd   <= {BCD_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b1;
            r_state <= ST_CONVERT;
          end else if (frame_start) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_PENDING;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign overflow = r_overflow;

  // Pixel stage 1: window test and tile/glyph coordinates. The 11-bit
  // offsets wrap when x < X0; the explicit >= tests keep that from hitting.
  logic [10:0] w_x_ext, w_y_ext, w_dx, w_dy, w_tile;
  logic        w_in_win;
  logic [3:0]  w_col;
  logic [4:0]  w_row;
  logic [3:0]  w_tile_code;

  assign w_x_ext  = {1'b0, x};
  assign w_y_ext  = {1'b0, y};
  assign w_dx     = w_x_ext - 11'(X0);
  assign w_dy     = w_y_ext - 11'(Y0);
  assign w_in_win = (w_x_ext >= 11'(X0)) && (w_dx < 11'(N_CHARS * TW)) &&
                    (w_y_ext >= 11'(Y0)) && (w_dy < 11'(TH));
  assign w_tile   = w_dx >> (4 + SCALE_LOG2);
  assign w_col    = 4'(w_dx >> SCALE_LOG2);
  assign w_row    = 5'(w_dy >> SCALE_LOG2);

  // Select the committed code of the tile under the pixel.
  always_comb begin
    w_tile_code = CODE_BLANK;
    for (int i = 0; i < N_CHARS; i++) begin
      if (w_tile == 11'(i)) begin
        w_tile_code = r_codes[i];
      end else begin
        w_tile_code = w_tile_code;
      end
    end
  end

  logic       r_s1_in;
  logic [3:0] r_s1_code;
  logic [3:0] r_s1_col;
  logic [4:0] r_s1_row;
  logic       r_on;

  // Two-stage pixel pipeline: coordinates/code, then glyph lookup.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_in   <= 1'b0;
      r_s1_code <= CODE_BLANK;
      r_s1_col  <= 4'd0;
      r_s1_row  <= 5'd0;
      r_on      <= 1'b0;
    end else begin
      r_s1_in   <= w_in_win;
      r_s1_code <= w_tile_code;
      r_s1_col  <= w_col;
      r_s1_row  <= w_row;
      r_on      <= r_s1_in && glyph_bit(r_s1_code, r_s1_row, r_s1_col);
    end
  end

  assign on_char = r_on;

endmodule

// File: tb/tb_numeric_readout.sv
module tb_numeric_readout;

  localparam int X0 = 8;
  localparam int Y0 = 4;
  localparam int VW = 10;
  localparam int NI = 3;   // inst 0: defaults, inst 1: LZ_BLANK=0, inst 2: SCALE_LOG2=1

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [9:0]    x = 10'd0, y = 10'd0;
  logic          frame_start = 1'b0;
  logic [VW-1:0] value = '0;
  logic          value_valid = 1'b0;
  logic [NI-1:0] busy, overflow, on_char;

  always #5 clk = ~clk;

  numeric_readout #(.X0(X0), .Y0(Y0), .N_DIGITS(3), .VALUE_W(VW), .SCALE_LOG2(0),
                    .LZ_BLANK(1), .UNIT_DEGREE(1)) u_dut0 (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_start(frame_start),
    .value(value), .value_valid(value_valid),
    .busy(busy[0]), .overflow(overflow[0]), .on_char(on_char[0]));

  numeric_readout #(.X0(X0), .Y0(Y0), .N_DIGITS(3), .VALUE_W(VW), .SCALE_LOG2(0),
                    .LZ_BLANK(0), .UNIT_DEGREE(1)) u_dut1 (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_start(frame_start),
    .value(value), .value_valid(value_valid),
    .busy(busy[1]), .overflow(overflow[1]), .on_char(on_char[1]));

  numeric_readout #(.X0(X0), .Y0(Y0), .N_DIGITS(3), .VALUE_W(VW), .SCALE_LOG2(1),
                    .LZ_BLANK(1), .UNIT_DEGREE(1)) u_dut2 (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_start(frame_start),
    .value(value), .value_valid(value_valid),
    .busy(busy[2]), .overflow(overflow[2]), .on_char(on_char[2]));

  // ---------------- reference model ----------------
  // Font: seven rectangles (top, upper-right, lower-right, bottom,
  // lower-left, upper-left, middle) and a per-digit set of them.
  int seg_r0 [7] = '{2, 2, 15, 27, 15, 2, 15};
  int seg_r1 [7] = '{4, 16, 29, 29, 29, 16, 16};
  int seg_c0 [7] = '{2, 11, 11, 2, 2, 2, 2};
  int seg_c1 [7] = '{13, 13, 13, 13, 4, 4, 13};
  int dig_segs [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  int  m_code [NI][4];
  int  m_mode;      // 0 idle, 1 converting, 2 result waiting
  int  m_rem;
  int  m_lat;
  bit  m_ovf;

  function automatic bit font(int code, int row, int col);
    if (code <= 9) begin
      for (int s = 0; s < 7; s++)
        if (((dig_segs[code] >> s) & 1) != 0 && row >= seg_r0[s] && row <= seg_r1[s] &&
            col >= seg_c0[s] && col <= seg_c1[s])
          return 1'b1;
      return 1'b0;
    end
    if (code == 11) return (row == 15 || row == 16) && col >= 3 && col <= 12;
    if (code == 12) return row >= 1 && row <= 6 && col >= 2 && col <= 7 &&
                           (row == 1 || row == 6 || col == 2 || col == 7);
    return 1'b0;
  endfunction

  function automatic bit exp_pixel(int k, int px, int py);
    int s, tw, th, tile;
    s  = (k == 2) ? 1 : 0;
    tw = 16 << s;
    th = 32 << s;
    if (px < X0 || px >= X0 + 4 * tw || py < Y0 || py >= Y0 + th) return 1'b0;
    tile = (px - X0) / tw;
    return font(m_code[k][tile], (py - Y0) >> s, ((px - X0) >> s) % 16);
  endfunction

  task automatic model_blank();
    for (int k = 0; k < NI; k++)
      for (int t = 0; t < 4; t++) m_code[k][t] = 10;
  endtask

  task automatic model_commit(int v);
    int d [3];
    m_ovf = (v >= 1000);
    d[0] = v / 100; d[1] = (v / 10) % 10; d[2] = v % 10;
    for (int k = 0; k < NI; k++) begin
      for (int t = 0; t < 3; t++) m_code[k][t] = m_ovf ? 11 : d[t];
      m_code[k][3] = 12;
      if (!m_ovf && k != 1) begin
        if (d[0] == 0) m_code[k][0] = 10;
        if (d[0] == 0 && d[1] == 0) m_code[k][1] = 10;
      end
    end
  endtask

  task automatic model_edge(bit vv, int v, bit fs, bit rst);
    if (rst) begin
      m_mode = 0; m_ovf = 1'b0; model_blank();
    end else if (m_mode == 0) begin
      if (vv) begin m_lat = v; m_rem = VW; m_mode = 1; end
    end else if (m_mode == 1) begin
      m_rem--;
      if (m_rem == 0) m_mode = 2;
    end else begin
      if (fs) model_commit(m_lat);
      if (vv) begin m_lat = v; m_rem = VW; m_mode = 1; end
      else if (fs) m_mode = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct { int due; int kind; int inst; int exp; } exp_t;
  exp_t sbq [$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   armed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation whose cycle has arrived and compares.
  initial begin
    exp_t e;
    int   act;
    string nm;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        case (e.kind)
          0:       begin act = int'(on_char[e.inst]);  nm = "on_char";  end
          1:       begin act = int'(busy[e.inst]);     nm = "busy";     end
          default: begin act = int'(overflow[e.inst]); nm = "overflow"; end
        endcase
        n_checks++;
        if (act != e.exp) begin
          n_fail++;
          $display("FAIL %s inst%0d cycle %0d: got %0d, expected %0d", nm, e.inst, cyc, act, e.exp);
        end
      end
    end
  end

  // One stimulus cycle; expectations are queued as the stimulus is issued.
  task automatic drive(bit vv, int v, bit fs, bit rst, int px, int py);
    int pix [NI];
    @(negedge clk);
    value_valid = vv; value = VW'(v); frame_start = fs; reset = rst;
    x = 10'(px); y = 10'(py);
    for (int k = 0; k < NI; k++) pix[k] = rst ? 0 : int'(exp_pixel(k, px, py));
    model_edge(vv, v, fs, rst);
    if (armed) begin
      if (rst)
        for (int i = 0; i < sbq.size(); i++)
          if (sbq[i].kind == 0 && sbq[i].due > cyc) sbq[i].exp = 0;
      for (int k = 0; k < NI; k++) begin
        sbq.push_back('{cyc + 1, 1, k, int'(m_mode == 1)});
        sbq.push_back('{cyc + 1, 2, k, int'(m_ovf)});
      end
      for (int k = 0; k < NI; k++) sbq.push_back('{cyc + 2, 0, k, pix[k]});
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) drive(0, 0, 0, 0, $urandom_range(0, 1023), $urandom_range(0, 1023));
      else drive(0, 0, 0, 0, $urandom_range(0, 139), $urandom_range(0, 69));
    end
  endtask

  task automatic strobe(int v);
    drive(1, v, 0, 0, $urandom_range(0, 139), $urandom_range(0, 69));
  endtask

  task automatic commit();
    drive(0, 0, 1, 0, $urandom_range(0, 139), $urandom_range(0, 69));
  endtask

  task automatic scan(int xmax, int ymax);
    for (int yy = 0; yy <= ymax; yy++)
      for (int xx = 0; xx <= xmax; xx++) drive(0, 0, 0, 0, xx, yy);
  endtask

  task automatic load(int v);
    strobe(v); idle(11); commit();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_mode = 0; m_rem = 0; m_lat = 0; m_ovf = 1'b0;
    model_blank();
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    armed = 1'b1;
    scan(139, 69);                 // nothing drawn before the first commit

    load(72);                      // BLANK 7 2 DEGREE
    scan(139, 69);

    load(1000);                    // overflow: dashes
    scan(75, 37);
    load(999);                     // overflow clears
    idle(4);

    load(5);                       // leading-zero blanking vs. 0 0 5
    scan(139, 37);
    load(0);
    scan(75, 37);

    strobe(72); idle(3); strobe(300); idle(10); commit();   // ignored during conversion
    scan(75, 37);
    strobe(72); idle(11); strobe(300); idle(11); commit();  // newest value wins
    scan(75, 37);

    strobe(123); idle(11);
    drive(1, 456, 1, 0, X0 + 20, Y0 + 15);                  // commit and relatch together
    idle(11); commit();
    scan(75, 37);

    strobe(72); idle(4);
    drive(0, 0, 0, 1, X0 + 50, Y0 + 1);                     // reset mid-conversion
    scan(75, 37);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 1023), $urandom_range(0, 24) == 0,
            $urandom_range(0, 399) == 0, $urandom_range(0, 139), $urandom_range(0, 69));
    end

    armed = 1'b0;
    idle(3);
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
